// File: rtl/draw_pkg.sv
// Shared drawing constants and the tile-reader state encoding.
package draw_pkg;

   localparam int TILE_W   = 4;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Delay line carrying a valid flag and 4-bit pixel index alongside each
// outstanding memory read, so returning data can be steered into its tile slot.
module read_tag_pipe #(
   parameter int READ_LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [3:0] in_index,
   output logic       out_valid,
   output logic [3:0] out_index
);

   logic [READ_LATENCY-1:0]      valid_reg;
   logic [READ_LATENCY-1:0][3:0] index_reg;

   // Advance every tag one stage per clock; reset empties the line so that
   // data still in flight from an aborted tile is never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= '0;
         index_reg <= '0;
      end else begin
         valid_reg[0] <= in_valid;
         index_reg[0] <= in_index;
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            index_reg[i] <= index_reg[i-1];
         end
      end
   end

   assign out_valid = valid_reg[READ_LATENCY-1];
   assign out_index = index_reg[READ_LATENCY-1];

endmodule

// File: rtl/square_reader.sv
// Reads a 4x4 pixel tile from a latency-READ_LATENCY pixel memory, row-major,
// and assembles it into a 48-bit word (3 bits per pixel, pixel 0 in the LSBs).
// Optional build macro SQUARE_READER_CLIP_EN: pixels falling off the 160x120
// screen are not read and their slots load 3'b000; timing is unchanged.
module square_reader
   import draw_pkg::*;
#(
   parameter int READ_LATENCY = 1   // legal range 1..3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic [7:0]  x_coords,
   input  logic [6:0]  y_coords,
   output logic        rd_en,
   output logic [7:0]  rd_x,
   output logic [6:0]  rd_y,
   input  logic [2:0]  rd_colour,
   output logic [47:0] tile,
   output logic        busy,
   output logic        done
);

   state_t      state_reg, state_next;
   logic [7:0]  base_x_reg;
   logic [6:0]  base_y_reg;
   logic [3:0]  pix_idx_reg;
   logic [1:0]  drain_cnt_reg;
   logic [47:0] tile_reg;

   logic        issuing;
   logic        accept;
   logic        in_range;
   logic [1:0]  x_off;
   logic [1:0]  y_off;
   logic        tag_valid;
   logic [3:0]  tag_index;
   logic [5:0]  slot_lsb;

   // Pixel index doubles as the row-major offset pair.
   assign x_off   = pix_idx_reg[1:0];
   assign y_off   = pix_idx_reg[3:2];
   assign issuing = (state_reg == ISSUE);
   assign accept  = (state_reg == IDLE) && go;

`ifdef SQUARE_READER_CLIP_EN
   logic [8:0] sum_x_wide;
   logic [7:0] sum_y_wide;
   assign sum_x_wide = {1'b0, base_x_reg} + {7'b0, x_off};
   assign sum_y_wide = {1'b0, base_y_reg} + {6'b0, y_off};
   assign in_range   = (sum_x_wide <= 9'(SCREEN_W - 1)) && (sum_y_wide <= 8'(SCREEN_H - 1));
`else
   assign in_range = 1'b1;
`endif

   // Addresses wrap at their port width; outside ISSUE they rest on the base.
   assign rd_x  = issuing ? (base_x_reg + {6'b0, x_off}) : base_x_reg;
   assign rd_y  = issuing ? (base_y_reg + {5'b0, y_off}) : base_y_reg;
   assign rd_en = issuing && in_range;
   assign tile  = tile_reg;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (go) state_next = ISSUE;
         end
         ISSUE: begin
            if (pix_idx_reg == 4'd15) state_next = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt_reg == 2'(READ_LATENCY - 1)) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Slot of the emerging tag: 3 * index.
   assign slot_lsb = {2'b00, tag_index} + {1'b0, tag_index, 1'b0};

   // Latch the base on go, walk the 16 pixels, time the drain and capture
   // returning colours into their slots.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_x_reg    <= '0;
         base_y_reg    <= '0;
         pix_idx_reg   <= '0;
         drain_cnt_reg <= '0;
         tile_reg      <= '0;
      end else begin
         if (accept) begin
            base_x_reg  <= x_coords;
            base_y_reg  <= y_coords;
            pix_idx_reg <= '0;
            tile_reg    <= '0;
         end
         if (issuing) pix_idx_reg <= pix_idx_reg + 4'd1;
         if (state_reg == DRAIN) drain_cnt_reg <= drain_cnt_reg + 2'd1;
         else                    drain_cnt_reg <= '0;
         if (tag_valid) tile_reg[slot_lsb +: 3] <= rd_colour;
      end
   end

   read_tag_pipe #(
      .READ_LATENCY(READ_LATENCY)
   ) u_tag_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_valid (rd_en),
      .in_index (pix_idx_reg),
      .out_valid(tag_valid),
      .out_index(tag_index)
   );

endmodule

// File: tb/tb_square_reader.sv
// Bench for square_reader: two instances (READ_LATENCY 1 and 3) share stimulus;
// a cycle-count model predicts every output each cycle.
module tb_square_reader;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic go = 1'b0;
   logic [7:0] x_coords = '0;
   logic [6:0] y_coords = '0;

   logic [1:0]       rd_en_s;
   logic [1:0][7:0]  rd_x_s;
   logic [1:0][6:0]  rd_y_s;
   logic [1:0][2:0]  rd_colour_s;
   logic [1:0][47:0] tile_s;
   logic [1:0]       busy_s;
   logic [1:0]       done_s;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int e0 = 0;
   int rd_cnt [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   int done_at [2] = '{0, 0};
   int last_done [2] = '{-1, -1};
   bit hold_mode = 1'b0;

`ifdef SQUARE_READER_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         localparam int L = (gi == 0) ? 1 : 3;
         logic [2:0] mem_pipe [L];

         square_reader #(.READ_LATENCY(L)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .go       (go),
            .x_coords (x_coords),
            .y_coords (y_coords),
            .rd_en    (rd_en_s[gi]),
            .rd_x     (rd_x_s[gi]),
            .rd_y     (rd_y_s[gi]),
            .rd_colour(rd_colour_s[gi]),
            .tile     (tile_s[gi]),
            .busy     (busy_s[gi]),
            .done     (done_s[gi])
         );

         // Pixel memory: colour (x+y)%8 appears L cycles after the strobe, noise otherwise.
         always @(posedge clk) begin
            mem_pipe[0] <= rd_en_s[gi] ? 3'(rd_x_s[gi] + {1'b0, rd_y_s[gi]}) : 3'($urandom);
            for (int i = 1; i < L; i++) mem_pipe[i] <= mem_pipe[i-1];
         end
         assign rd_colour_s[gi] = mem_pipe[L-1];
      end
   endgenerate

   // ---------------- behavioural model ----------------
   function automatic bit pix_in(input logic [7:0] bx, input logic [6:0] by, input int i);
      int xs;
      int ys;
      xs = int'(bx) + (i % 4);
      ys = int'(by) + (i / 4);
      return !CLIP || (xs <= 159 && ys <= 119);
   endfunction

   function automatic logic [47:0] tile_f(input logic [7:0] bx, input logic [6:0] by);
      logic [47:0] t;
      int xs;
      int ys;
      t = '0;
      for (int i = 0; i < 16; i++) begin
         xs = (int'(bx) + (i % 4)) % 256;
         ys = (int'(by) + (i / 4)) % 128;
         if (pix_in(bx, by, i)) t[3*i +: 3] = 3'((xs + ys) % 8);
      end
      return t;
   endfunction

   // k_m = cycles elapsed since go was accepted (0 when idle).
   int          k_m [2] = '{0, 0};
   logic [7:0]  bx_m [2] = '{8'd0, 8'd0};
   logic [6:0]  by_m [2] = '{7'd0, 7'd0};
   logic [47:0] et_m [2] = '{48'd0, 48'd0};
   bit          tk_m [2] = '{1'b1, 1'b1};

   always @(posedge clk or posedge reset) begin
      for (int g = 0; g < 2; g++) begin
         if (reset) begin
            k_m[g]  <= 0;
            bx_m[g] <= '0;
            by_m[g] <= '0;
            et_m[g] <= '0;
            tk_m[g] <= 1'b1;
         end else if (k_m[g] == 0) begin
            if (go) begin
               k_m[g]  <= 1;
               bx_m[g] <= x_coords;
               by_m[g] <= y_coords;
               et_m[g] <= tile_f(x_coords, y_coords);
               tk_m[g] <= 1'b0;
            end
         end else if (k_m[g] == 17 + lat_of(g)) begin
            k_m[g]  <= 0;
            tk_m[g] <= 1'b1;
         end else begin
            k_m[g] <= k_m[g] + 1;
         end
      end
   end

   task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [L=%0d] at cycle %0d: got %0h expected %0h", name, lat_of(g), cyc, act, exp);
      end
   endtask

   // Compare every cycle, plus transaction monitoring.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         int k;
         bit act_win;
         k = k_m[g];
         act_win = (k >= 1 && k <= 16);
         check("rd_en", g, rd_en_s[g], act_win && pix_in(bx_m[g], by_m[g], k - 1));
         check("rd_x", g, rd_x_s[g], act_win ? 8'(int'(bx_m[g]) + (k - 1) % 4) : bx_m[g]);
         check("rd_y", g, rd_y_s[g], act_win ? 7'(int'(by_m[g]) + (k - 1) / 4) : by_m[g]);
         check("busy", g, busy_s[g], k != 0);
         check("done", g, done_s[g], k == 17 + lat_of(g));
         if (tk_m[g] || k == 17 + lat_of(g)) check("tile", g, tile_s[g], et_m[g]);
         if (rd_en_s[g]) rd_cnt[g]++;
         if (done_s[g]) begin
            done_cnt[g]++;
            if (hold_mode && last_done[g] >= 0) check("done period", g, cyc - last_done[g], 18 + lat_of(g));
            done_at[g]   = cyc;
            last_done[g] = cyc;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_tile(input logic [7:0] x, input logic [6:0] y);
      @(posedge clk);
      #2;
      go = 1'b1;
      x_coords = x;
      y_coords = y;
      @(posedge clk);
      #1;
      e0 = cyc;
      for (int g = 0; g < 2; g++) begin
         rd_cnt[g] = 0;
         done_cnt[g] = 0;
      end
      #1;
      go = 1'b0;
      $display("tile request x=%0d y=%0d accepted at cycle %0d", x, y, e0);
   endtask

   task automatic wait_both(input int budget);
      int n;
      n = 0;
      while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done timeout", 0, (done_cnt[0] > 0 && done_cnt[1] > 0), 1);
      @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         check("reset busy", g, busy_s[g], 0);
         check("reset done", g, done_s[g], 0);
         check("reset rd_en", g, rd_en_s[g], 0);
         check("reset rd_x", g, rd_x_s[g], 0);
         check("reset tile", g, tile_s[g], 0);
      end
      #2 reset = 1'b0;

      // Basic tile at (10,20)
      start_tile(8'd10, 7'd20);
      wait_both(60);
      for (int g = 0; g < 2; g++) begin
         check("done cycle", g, done_at[g] - e0 + 1, (g == 0) ? 18 : 20);
         check("read count", g, rd_cnt[g], 16);
         check("pixel0", g, tile_s[g][2:0], 3'd6);
         check("pixel15", g, tile_s[g][47:45], 3'd4);
      end

      // Edge of screen at (158,118)
      start_tile(8'd158, 7'd118);
      wait_both(60);
      for (int g = 0; g < 2; g++) begin
         check("edge read count", g, rd_cnt[g], CLIP ? 16'd4 : 16'd16);
         check("edge pixel0", g, tile_s[g][2:0], 3'd4);
         check("edge pixel2", g, tile_s[g][8:6], CLIP ? 3'd0 : 3'd6);
         check("edge pixel5", g, tile_s[g][17:15], 3'd6);
         check("edge pixel15", g, tile_s[g][47:45], CLIP ? 3'd0 : 3'd2);
      end

      // go re-pulsed during ISSUE is ignored
      start_tile(8'd30, 7'd40);
      repeat (4) @(posedge clk);
      #2;
      go = 1'b1;
      x_coords = 8'd99;
      y_coords = 7'd99;
      @(posedge clk);
      #2 go = 1'b0;
      wait_both(60);
      repeat (30) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("repulse done count", g, done_cnt[g], 1);
         check("repulse pixel0", g, tile_s[g][2:0], 3'd6);
      end

      // Reset in cycle 8 aborts the tile
      start_tile(8'd5, 7'd5);
      repeat (7) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      $display("reset asserted mid-tile at cycle %0d", cyc);
      for (int g = 0; g < 2; g++) begin
         check("abort busy", g, busy_s[g], 0);
         check("abort tile", g, tile_s[g], 0);
         check("abort rd_en", g, rd_en_s[g], 0);
      end
      @(posedge clk);
      #3 reset = 1'b0;
      repeat (30) @(negedge clk);
      for (int g = 0; g < 2; g++) check("abort no done", g, done_cnt[g], 0);
      start_tile(8'd1, 7'd2);
      wait_both(60);
      for (int g = 0; g < 2; g++) begin
         check("post-reset done cycle", g, done_at[g] - e0 + 1, (g == 0) ? 18 : 20);
         check("post-reset pixel0", g, tile_s[g][2:0], 3'd3);
      end

      // go held high: back-to-back tiles
      for (int g = 0; g < 2; g++) begin
         done_cnt[g] = 0;
         last_done[g] = -1;
      end
      hold_mode = 1'b1;
      @(posedge clk);
      #2;
      go = 1'b1;
      x_coords = 8'd50;
      y_coords = 7'd60;
      $display("go held high from cycle %0d", cyc);
      repeat (75) @(posedge clk);
      #2 go = 1'b0;
      repeat (30) @(posedge clk);
      hold_mode = 1'b0;
      for (int g = 0; g < 2; g++) check("held done count", g, done_cnt[g], 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
